regfile_scan_ctrl: RTL and testbench
====================================

Name: regfile_scan_ctrl

Overview:
- Serial debug/scan controller that gives a JTAG-style one-bit interface read and write access to a general register file.
- Sits between the pipeline write-back stage and the register file write port and shares that port. The core always has priority; debug writes wait for a free cycle.
- Uses one register file read port for debug reads.
- Frame format is op bit, then address, then data, LSB first throughout.

Parameters:
- SIZE, 16, number of registers; ADDR_W = $clog2(SIZE).
- WIDTH, 32, register width; CNT_W = $clog2(WIDTH)+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- sEnable  in  1  serial qualifier; shifting happens only in cycles where it is 1
- sIn  in  1  serial data in
- sOut  out  1  serial data out
- sDone  out  1  one-cycle pulse when a frame completes
- busy  out  1  high when state != IDLE
- stallReq  out  1  asks the core to drop coreWe (high in WRITE)
- coreWe  in  1  core write enable
- coreWAddr  in  ADDR_W  core write address
- coreWData  in  WIDTH  core write data
- rfWe  out  1  to register file writeEnable1
- rfWAddr  out  ADDR_W  to register file writeAddr1
- rfWData  out  WIDTH  to register file writeData1
- rfRAddr  out  ADDR_W  to a register file read address port
- rfRData  in  WIDTH  from the matching register file read data port

Behaviour:
- Reset: rst, asynchronous, active-low; clock clk.
- Values held while rst is low: state=IDLE, opReg/addrReg/shReg/cnt=0, sOut=0, sDone=0, busy=0, stallReq=0.
- Reset mid-frame aborts the frame with no register file write.
- States: IDLE, ADDR, DATA_IN, WRITE, READ, DATA_OUT. All transitions are on posedge clk.
- In every shifting state, a cycle with sEnable=0 pauses: no shift, count holds, state holds.
- IDLE:
  - On sEnable=1, opReg<=sIn (1=write, 0=read), cnt<=0, go to ADDR.
- ADDR:
  - Each sEnable cycle: addrReg<={sIn, addrReg[ADDR_W-1:1]}, cnt++.
  - After ADDR_W bits, cnt<=0 and go to DATA_IN if opReg=1, else READ.
- DATA_IN:
  - Each sEnable cycle: shReg<={sIn, shReg[WIDTH-1:1]}, cnt++.
  - After WIDTH bits, go to WRITE.
- WRITE:
  - stallReq=1.
  - If coreWe=0: dbgWe=1 for this cycle; next state IDLE; sDone=1 in the next cycle.
  - If coreWe=1: the core write proceeds and the controller stays in WRITE. No timeout.
- READ (one cycle):
  - rfRAddr=addrReg; shReg<=rfRData; cnt<=0; go to DATA_OUT.
- DATA_OUT:
  - sOut=shReg[0] combinationally.
  - Each sEnable cycle: shReg>>=1, cnt++.
  - After WIDTH shifts, go to IDLE; sDone=1 in the next cycle.
- sOut is 0 in every state other than DATA_OUT.
- sDone is registered and lasts exactly one cycle. A new frame may start in the IDLE cycle where sDone=1.
- rfRAddr is addrReg in all states, including when not in READ.
- Write port mux (combinational):
  - rfWe = coreWe | dbgWe.
  - When coreWe=1: rfWAddr/rfWData come from the core.
  - Otherwise: rfWAddr = addrReg, rfWData = shReg.
  - The core and the debug write are never issued in the same cycle.
- Address 0:
  - A write to address 0 still issues rfWe and sDone; the register file discards the write.
  - A read of address 0 returns 0 from the register file and shifts out zeros.
- Frame length (sEnable held high throughout):
  - Write frame: 1+ADDR_W+WIDTH shift cycles, plus ≥1 WRITE cycle.
  - Read frame: 1+ADDR_W shift cycles, then 1 READ cycle, then WIDTH output cycles.

Test Plan:
- Write with no contention:
  - Stimulus: reset; sEnable=1; shift bits 1, 1,0,1,0 (addr 5); then 0xDEADBEEF LSB first.
  - Required: rfWe=1 with rfWAddr=5 and rfWData=0xDEADBEEF in cycle 38; sDone pulses in cycle 39; busy=0 afterwards.
- Read-back:
  - Stimulus: frame 0, 1,0,1,0 into the same register file model.
  - Required: READ cycle, then sOut emits 0xDEADBEEF LSB first over 32 cycles; sDone follows; rfWe never asserted.
- Contention:
  - Stimulus: coreWe=1 (addr 3, 0x11111111) held for 3 cycles starting when the debug write enters WRITE.
  - Required: core write to r3 each of those cycles; stallReq=1 throughout; debug write lands in the 4th cycle; both values are correct afterwards.
- Pause:
  - Stimulus: drop sEnable for 5 cycles mid-address and 7 cycles mid-data.
  - Required: same register file result as the first write scenario, completed 12 cycles later.
- Reset mid-frame:
  - Stimulus: assert rst after 20 data bits.
  - Required: immediately sOut=0, busy=0, state IDLE; no rfWe; a following complete frame works normally.
- Address 0:
  - Stimulus: write 0xFFFFFFFF to r0, then read r0.
  - Required: rfWe pulses with addr 0; the read shifts out 32 zeros.

Source files
------------

// File: rtl/regfile_scan_ctrl.sv
// One-bit scan controller giving serial read/write access to a register file.
// Debug writes share the core write port and only land in cycles where the core is idle.
module regfile_scan_ctrl #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned ADDR_W = $clog2(SIZE),
    localparam int unsigned CNT_W  = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sEnable,
    input  logic              sIn,
    output logic              sOut,
    output logic              sDone,
    output logic              busy,
    output logic              stallReq,
    input  logic              coreWe,
    input  logic [ADDR_W-1:0] coreWAddr,
    input  logic [WIDTH-1:0]  coreWData,
    output logic              rfWe,
    output logic [ADDR_W-1:0] rfWAddr,
    output logic [WIDTH-1:0]  rfWData,
    output logic [ADDR_W-1:0] rfRAddr,
    input  logic [WIDTH-1:0]  rfRData
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StDataIn,
        StWrite,
        StRead,
        StDataOut
    } state_e;

    state_e             state_q, state_d;
    logic               op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               dbg_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            op_q    <= 1'b0;
            addr_q  <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        dbg_we   = 1'b0;
        stallReq = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sEnable) begin
                    op_d    = sIn;
                    cnt_d   = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (sEnable) begin
                    addr_d = {sIn, addr_q[ADDR_W-1:1]};
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        cnt_d   = '0;
                        state_d = op_q ? StDataIn : StRead;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDataIn: begin
                if (sEnable) begin
                    sh_d = {sIn, sh_q[WIDTH-1:1]};
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = StWrite;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWrite: begin
                // The core owns the port whenever it writes; wait here as long as needed.
                stallReq = 1'b1;
                if (!coreWe) begin
                    dbg_we  = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StRead: begin
                sh_d    = rfRData;
                cnt_d   = '0;
                state_d = StDataOut;
            end
            StDataOut: begin
                if (sEnable) begin
                    sh_d = sh_q >> 1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sOut    = (state_q == StDataOut) & sh_q[0];
    assign sDone   = done_q;
    assign busy    = (state_q != StIdle);
    assign rfRAddr = addr_q;

    assign rfWe    = coreWe | dbg_we;
    assign rfWAddr = coreWe ? coreWAddr : addr_q;
    assign rfWData = coreWe ? coreWData : sh_q;

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Directed bench for regfile_scan_ctrl with a behavioural 16x32 register file
// (r0 reads as zero, writes to r0 discarded).
module tb_regfile_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        sEnable;
    logic        sIn;
    logic        sOut;
    logic        sDone;
    logic        busy;
    logic        stallReq;
    logic        coreWe;
    logic [3:0]  coreWAddr;
    logic [31:0] coreWData;
    logic        rfWe;
    logic [3:0]  rfWAddr;
    logic [31:0] rfWData;
    logic [3:0]  rfRAddr;
    logic [31:0] rfRData;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned cyc;
    int unsigned dbg_we_cnt;
    logic        mem_clr;
    logic [31:0] mem [16];

    regfile_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .sEnable   (sEnable),
        .sIn       (sIn),
        .sOut      (sOut),
        .sDone     (sDone),
        .busy      (busy),
        .stallReq  (stallReq),
        .coreWe    (coreWe),
        .coreWAddr (coreWAddr),
        .coreWData (coreWData),
        .rfWe      (rfWe),
        .rfWAddr   (rfWAddr),
        .rfWData   (rfWData),
        .rfRAddr   (rfRAddr),
        .rfRData   (rfRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rfWe && !coreWe) dbg_we_cnt <= dbg_we_cnt + 1;
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (rfWe && rfWAddr != 4'd0) begin
            mem[rfWAddr] <= rfWData;
        end
    end

    assign rfRData = (rfRAddr == 4'd0) ? 32'h0 : mem[rfRAddr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1);
    end

    // Stimulus helpers: bits are sampled at the next rising edge; return 1 unit after it.
    task automatic shift_bit(input logic b);
        sEnable = 1'b1;
        sIn     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        sEnable = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_header(input logic op, input logic [3:0] a);
        shift_bit(op);
        for (int i = 0; i < 4; i++) shift_bit(a[i]);
    endtask

    task automatic send_data(input logic [31:0] d, input int from, input int to);
        for (int i = from; i < to; i++) shift_bit(d[i]);
    endtask

    // Full write frame; returns in the first WRITE cycle with sEnable low.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        send_header(1'b1, a);
        send_data(d, 0, 32);
        sEnable = 1'b0;
        #1;
    endtask

    // Full read frame; returns in the cycle after the last output bit (sDone cycle).
    task automatic do_read(input logic [3:0] a, output logic [31:0] got);
        send_header(1'b0, a);
        sEnable = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            got[i] = sOut;
            shift_bit(1'b0);
        end
        sEnable = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst       = 1'b0;
        sEnable   = 1'b0;
        sIn       = 1'b0;
        coreWe    = 1'b0;
        coreWAddr = '0;
        coreWData = '0;
        mem_clr   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        n_checks++;
        if ({sOut, sDone, busy, stallReq, rfWe} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 00000", {sOut, sDone, busy, stallReq, rfWe});
        end
        n_checks++;
        if (rfRAddr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_raddr: got %0d, required 0", rfRAddr);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_basic;
        int unsigned c0;
        c0 = cyc;
        do_write(4'd5, 32'hDEADBEEF);
        n_checks++;
        if (cyc - c0 !== 37) begin
            n_fail++;
            $display("FAIL write_latency: got %0d shift cycles, required 37", cyc - c0);
        end
        n_checks++;
        if ({rfWe, stallReq, busy, rfWAddr, rfWData} !== {3'b111, 4'd5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL write_port: got we=%b stall=%b busy=%b addr=%0d data=%h, required 1 1 1 5 deadbeef",
                     rfWe, stallReq, busy, rfWAddr, rfWData);
        end
        n_checks++;
        if (rfRAddr !== 4'd5) begin
            n_fail++;
            $display("FAIL write_raddr: got %0d, required 5", rfRAddr);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({sDone, busy, rfWe, stallReq} !== 4'b1000) begin
            n_fail++;
            $display("FAIL write_done: got done/busy/we/stall=%b, required 1000", {sDone, busy, rfWe, stallReq});
        end
        n_checks++;
        if (mem[5] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_mem: got r5=%h, required deadbeef", mem[5]);
        end
    endtask

    // Starts in the sDone cycle of the preceding write to exercise back-to-back frames.
    task automatic test_read_back;
        int unsigned we0;
        logic [31:0] got;
        we0 = dbg_we_cnt;
        shift_bit(1'b0);
        n_checks++;
        if ({sDone, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL read_start: got done/busy=%b, required 01", {sDone, busy});
        end
        send_data(32'h5, 0, 4);
        n_checks++;
        if ({busy, sOut, rfRAddr} !== {2'b10, 4'd5}) begin
            n_fail++;
            $display("FAIL read_state: got busy=%b sOut=%b raddr=%0d, required 1 0 5", busy, sOut, rfRAddr);
        end
        sEnable = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            got[i] = sOut;
            shift_bit(1'b1);
        end
        sEnable = 1'b0;
        #1;
        n_checks++;
        if (got !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL read_data: got %h, required deadbeef", got);
        end
        n_checks++;
        if ({sDone, busy, sOut} !== 3'b100) begin
            n_fail++;
            $display("FAIL read_done: got done/busy/sOut=%b, required 100", {sDone, busy, sOut});
        end
        n_checks++;
        if (dbg_we_cnt !== we0) begin
            n_fail++;
            $display("FAIL read_no_we: got %0d debug writes, required %0d", dbg_we_cnt, we0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention;
        do_write(4'd7, 32'hCAFEF00D);
        coreWe    = 1'b1;
        coreWAddr = 4'd3;
        coreWData = 32'h11111111;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({rfWe, stallReq, busy, rfWAddr, rfWData} !== {3'b111, 4'd3, 32'h11111111}) begin
                n_fail++;
                $display("FAIL contention_core%0d: got we=%b stall=%b busy=%b addr=%0d data=%h, required 1 1 1 3 11111111",
                         i, rfWe, stallReq, busy, rfWAddr, rfWData);
            end
            @(posedge clk);
            #1;
        end
        coreWe = 1'b0;
        #1;
        n_checks++;
        if ({rfWe, stallReq, rfWAddr, rfWData} !== {2'b11, 4'd7, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL contention_dbg: got we=%b stall=%b addr=%0d data=%h, required 1 1 7 cafef00d",
                     rfWe, stallReq, rfWAddr, rfWData);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({sDone, busy, mem[3], mem[7]} !== {2'b10, 32'h11111111, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL contention_result: got done=%b busy=%b r3=%h r7=%h, required 1 0 11111111 cafef00d",
                     sDone, busy, mem[3], mem[7]);
        end
    endtask

    task automatic test_pause;
        int unsigned c0;
        int unsigned we0;
        c0  = cyc;
        we0 = dbg_we_cnt;
        shift_bit(1'b1);
        shift_bit(1'b1);
        shift_bit(1'b0);
        idle_cycles(5);
        shift_bit(1'b0);
        shift_bit(1'b1);
        send_data(32'hDEADBEEF, 0, 10);
        idle_cycles(7);
        n_checks++;
        if ({busy, rfWe} !== 2'b10 || dbg_we_cnt !== we0) begin
            n_fail++;
            $display("FAIL pause_hold: got busy=%b we=%b writes=%0d, required 1 0 %0d",
                     busy, rfWe, dbg_we_cnt, we0);
        end
        send_data(32'hDEADBEEF, 10, 32);
        sEnable = 1'b0;
        #1;
        n_checks++;
        if (cyc - c0 !== 49) begin
            n_fail++;
            $display("FAIL pause_latency: got %0d cycles, required 49", cyc - c0);
        end
        n_checks++;
        if ({rfWe, rfWAddr, rfWData} !== {1'b1, 4'd9, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL pause_port: got we=%b addr=%0d data=%h, required 1 9 deadbeef", rfWe, rfWAddr, rfWData);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({sDone, mem[9]} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL pause_result: got done=%b r9=%h, required 1 deadbeef", sDone, mem[9]);
        end
    endtask

    task automatic test_reset_mid_frame;
        int unsigned we0;
        we0 = dbg_we_cnt;
        send_header(1'b1, 4'd4);
        send_data(32'h12345678, 0, 20);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({sOut, busy, sDone, stallReq, rfWe} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_write: got sOut/busy/done/stall/we=%b, required 00000",
                     {sOut, busy, sDone, stallReq, rfWe});
        end
        repeat (3) shift_bit(1'b1);
        sEnable = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy, mem[4]} !== 33'h0 || dbg_we_cnt !== we0) begin
            n_fail++;
            $display("FAIL abort_no_write: got busy=%b r4=%h writes=%0d, required 0 0 %0d",
                     busy, mem[4], dbg_we_cnt, we0);
        end
        // Abort a read while a 1 is on sOut.
        send_header(1'b0, 4'd5);
        sEnable = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) shift_bit(1'b0);
        n_checks++;
        if (sOut !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_read_bit3: got %b, required 1", sOut);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({sOut, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_read: got sOut/busy=%b, required 00", {sOut, busy});
        end
        sEnable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_write(4'd4, 32'h0F0F0F0F);
        @(posedge clk);
        #1;
        n_checks++;
        if ({sDone, mem[4]} !== {1'b1, 32'h0F0F0F0F}) begin
            n_fail++;
            $display("FAIL after_abort: got done=%b r4=%h, required 1 0f0f0f0f", sDone, mem[4]);
        end
    endtask

    task automatic test_addr_zero;
        logic [31:0] got;
        @(posedge clk);
        #1;
        do_write(4'd0, 32'hFFFFFFFF);
        n_checks++;
        if ({rfWe, rfWAddr, rfWData} !== {1'b1, 4'd0, 32'hFFFFFFFF}) begin
            n_fail++;
            $display("FAIL zero_write: got we=%b addr=%0d data=%h, required 1 0 ffffffff", rfWe, rfWAddr, rfWData);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (sDone !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: got %b, required 1", sDone);
        end
        do_read(4'd0, got);
        n_checks++;
        if ({sDone, got} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL zero_read: got done=%b data=%h, required 1 00000000", sDone, got);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        dbg_we_cnt = 0;
        test_reset();
        test_write_basic();
        test_read_back();
        test_contention();
        test_pause();
        test_reset_mid_frame();
        test_addr_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
